clint_mh: RTL

Multi-hart core-local interruptor: one shared 64-bit `mtime` advanced by a programmable prescaler, plus a per-hart `mtimecmp` compare register and a per-hart `msip` software-interrupt bit. It sits on the core's uncached MMIO path. It drives `timer_int`/`soft_int` vectors into each hart's CSR/trap logic. It is the N-hart generalisation of the single-hart timer, adding software interrupts, byte-lane writes, debug halt and a valid-qualified read return.

---
 rtl/clint_pkg.sv | 28 ++
 rtl/clint_mh_if.sv | 20 ++
 rtl/clint_prescaler.sv | 31 +++
 rtl/clint_mh.sv | 134 +++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT address map, region decode type and byte-lane merge helper.
// Used by the CLINT top and by anything that decodes the CLINT window.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_ADDR    = 16'hBFF8;

  typedef enum logic [1:0] {
    RegNone,
    RegMsip,
    RegMtimecmp,
    RegMtime
  } clint_region_e;

  // Bytes with their enable set come from new_val; the rest keep old_val.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  we);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (we[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mh_if.sv
// MMIO access bundle between the core's uncached path and the CLINT.
// One strobe per access; read data returns one cycle later with a valid pulse.
interface clint_mh_if;
  logic        clint_en;
  logic [7:0]  clint_we;
  logic [63:0] clint_addr;
  logic [63:0] clint_wdata;
  logic [63:0] clint_rdata;
  logic        clint_rvalid;

  modport master (
    output clint_en, clint_we, clint_addr, clint_wdata,
    input  clint_rdata, clint_rvalid
  );

  modport slave (
    input  clint_en, clint_we, clint_addr, clint_wdata,
    output clint_rdata, clint_rvalid
  );
endinterface

// File: rtl/clint_prescaler.sv
// Divides clk down to a one-cycle mtime tick every TICK_DIV unhalted cycles.
// Halt freezes the phase so timekeeping resumes where it stopped.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 50
) (
  input  logic clk,
  input  logic resetn,
  input  logic halt,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_max;

  assign at_max = (cnt_q == CntMax);
  assign tick   = at_max & ~halt;

  always_comb begin
    cnt_d = cnt_q;
    if (!halt) cnt_d = at_max ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart CLINT: shared prescaled mtime, per-hart mtimecmp and msip,
// byte-lane MMIO writes and registered one-cycle read return.
module clint_mh
  import clint_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 2,
  parameter int unsigned TICK_DIV  = 50
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 time_halt,
  clint_mh_if.slave            bus,
  output logic [NUM_HARTS-1:0] timer_int,
  output logic [NUM_HARTS-1:0] soft_int
);

  localparam int unsigned MsipWords = (NUM_HARTS + 1) / 2;
  localparam logic [12:0] MsipDw    = CLINT_MSIP_BASE[15:3];
  localparam logic [12:0] CmpDw     = CLINT_MTIMECMP_BASE[15:3];
  localparam logic [12:0] MtimeDw   = CLINT_MTIME_ADDR[15:3];

  logic                 tick;
  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [63:0]          rdata_q, rdata_d;
  logic                 rvalid_q;
  logic [NUM_HARTS-1:0] timer_q, soft_q, cmp_hit;

  logic [12:0]   dw, msip_off, cmp_off;
  clint_region_e region;
  logic [63:0]   rd_word, wr_word;
  logic          wr_en;
  logic          unused_addr;

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .resetn (resetn),
    .halt   (time_halt),
    .tick   (tick)
  );

  assign dw          = bus.clint_addr[15:3];
  assign msip_off    = dw - MsipDw;
  assign cmp_off     = dw - CmpDw;
  assign wr_en       = bus.clint_en & (|bus.clint_we);
  assign unused_addr = ^{bus.clint_addr[63:16], bus.clint_addr[2:0]};

  // Offsets below a base wrap to large values, so one compare bounds each region.
  always_comb begin
    region = RegNone;
    if (dw == MtimeDw)                      region = RegMtime;
    else if (cmp_off < 13'(NUM_HARTS))      region = RegMtimecmp;
    else if (msip_off < 13'(MsipWords))     region = RegMsip;
  end

  always_comb begin
    rd_word = '0;
    unique case (region)
      RegNone:  rd_word = '0;
      RegMtime: rd_word = mtime_q;
      RegMtimecmp: begin
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
          if (cmp_off == 13'(h)) rd_word = mtimecmp_q[h];
        end
      end
      RegMsip: begin
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
          if (msip_off == 13'(h / 2)) begin
            if (h % 2 == 0) rd_word[0]  = msip_q[h];
            else            rd_word[32] = msip_q[h];
          end
        end
      end
    endcase
  end

  assign wr_word = byte_merge(rd_word, bus.clint_wdata, bus.clint_we);

  always_comb begin
    // Overlay on the incremented value so a tick carry survives in unwritten lanes.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en && region == RegMtime) begin
      mtime_d = byte_merge(mtime_d, bus.clint_wdata, bus.clint_we);
    end

    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      mtimecmp_d[h] = mtimecmp_q[h];
      if (wr_en && region == RegMtimecmp && cmp_off == 13'(h)) mtimecmp_d[h] = wr_word;
    end

    msip_d = msip_q;
    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      if (wr_en && region == RegMsip && msip_off == 13'(h / 2)) begin
        msip_d[h] = (h % 2 == 0) ? wr_word[0] : wr_word[32];
      end
    end

    rdata_d = bus.clint_en ? rd_word : rdata_q;
  end

  for (genvar h = 0; h < int'(NUM_HARTS); h++) begin : g_cmp
    assign cmp_hit[h] = (mtime_q >= mtimecmp_q[h]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtime_q  <= '0;
      msip_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      timer_q  <= '0;
      soft_q   <= '0;
      for (int h = 0; h < int'(NUM_HARTS); h++) mtimecmp_q[h] <= '1;
    end else begin
      mtime_q  <= mtime_d;
      msip_q   <= msip_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.clint_en;
      timer_q  <= cmp_hit;
      soft_q   <= msip_q;
      for (int h = 0; h < int'(NUM_HARTS); h++) mtimecmp_q[h] <= mtimecmp_d[h];
    end
  end

  assign bus.clint_rdata  = rdata_q;
  assign bus.clint_rvalid = rvalid_q;
  assign timer_int        = timer_q;
  assign soft_int         = soft_q;

endmodule
